// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT block receiver.
// Contents:
//   rx_state_e     receiver FSM states
//   CRC16_POLY     CCITT CRC16 polynomial used on every DAT line
//   START_PATTERN  DAT[3:0] value of the start bit
//   END_PATTERN    DAT[3:0] value of the end bit
package sd_dat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } rx_state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [3:0]  START_PATTERN = 4'b0000;
  localparam logic [3:0]  END_PATTERN   = 4'b1111;

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16 (MSB first, init 0) for one SD DAT line.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset, clears the CRC
//   clear_i   clears the CRC (has priority over en_i)
//   en_i      shift bit_in_i into the CRC this cycle
//   bit_in_i  received line bit
//   crc_o     current CRC remainder
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_in_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        feedback;

  // Next remainder: shift left, folding in the polynomial when the
  // incoming bit differs from the outgoing MSB.
  always_comb begin
    feedback = bit_in_i ^ crc_q[15];
    crc_d    = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

  // Remainder register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_block_rx.sv
// Receive framer for one 4-bit SD DAT block: start bit, payload bytes,
// per-line CRC16 and end bit. Payload goes out on a valid/ready stream.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   sample_en_i          one-cycle pulse per SD clock sampling point
//   dat_in_i[3:0]        sampled DAT lines (DAT3 = bit 3)
//   start_i, abort_i     arm / cancel reception of one block
//   busy_o               reception in progress
//   out_data_o/valid_o   payload byte stream, accepted with out_ready_i
//   done_o               one-cycle pulse after the end bit
//   crc_err_o            sticky CRC mismatch or bad end bit
//   timeout_o            sticky missing start bit
//   overrun_o            sticky byte dropped because the previous one was held
module sd_dat_block_rx
  import sd_dat_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TIMEOUT_TICKS = 250000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sample_en_i,
  input  logic [3:0] dat_in_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       done_o,
  output logic       crc_err_o,
  output logic       timeout_o,
  output logic       overrun_o
);

  localparam int NIBBLES = 2 * BLOCK_BYTES;
  localparam int NW      = $clog2(NIBBLES);
  localparam int TW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_TICKS);

  rx_state_e   state_q, state_d;
  logic [NW-1:0] nib_cnt_q, nib_cnt_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic        crc_err_q, crc_err_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;

  logic        crc_clear;
  logic        crc_en;
  logic        crc_mismatch;
  logic [15:0] crc_w [4];

  // An abort in the same cycle as a sample point must not advance the CRCs.
  assign crc_clear = (state_q == ST_WAIT_START) && sample_en_i && !abort_i &&
                     (dat_in_i == START_PATTERN);
  assign crc_en    = (state_q == ST_DATA) && sample_en_i && !abort_i;

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16_serial u_crc (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clear_i  (crc_clear),
      .en_i     (crc_en),
      .bit_in_i (dat_in_i[i]),
      .crc_o    (crc_w[i])
    );
  end

  // During the CRC phase, tick k carries bit 15-k of each line's remainder.
  always_comb begin
    crc_mismatch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dat_in_i[i] != crc_w[i][4'd15 - crc_cnt_q]) begin
        crc_mismatch = 1'b1;
      end
    end
  end

  // Next-state and output logic. Abort overrides everything outside IDLE;
  // the byte slot frees on a handshake, and a completed byte arriving while
  // the slot is still held is dropped and flagged as overrun.
  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    hi_d        = hi_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    crc_err_d   = crc_err_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d    = ST_WAIT_START;
            crc_err_d  = 1'b0;
            timeout_d  = 1'b0;
            overrun_d  = 1'b0;
            tick_cnt_d = '0;
          end
        end
        ST_WAIT_START: begin
          if (sample_en_i) begin
            if (dat_in_i == START_PATTERN) begin
              state_d   = ST_DATA;
              nib_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
              if (tick_cnt_q + TW'(1) == TO_LIMIT) begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end
          end
        end
        ST_DATA: begin
          if (sample_en_i) begin
            if (!nib_cnt_q[0]) begin
              hi_d = dat_in_i;
            end else if (out_valid_q && !out_ready_i) begin
              overrun_d = 1'b1;
            end else begin
              out_data_d  = {hi_q, dat_in_i};
              out_valid_d = 1'b1;
            end
            if (nib_cnt_q == LAST_NIB) begin
              state_d   = ST_CRC;
              crc_cnt_d = '0;
            end else begin
              nib_cnt_d = nib_cnt_q + NW'(1);
            end
          end
        end
        ST_CRC: begin
          if (sample_en_i) begin
            if (crc_mismatch) begin
              crc_err_d = 1'b1;
            end
            if (crc_cnt_q == 4'd15) begin
              state_d = ST_END;
            end else begin
              crc_cnt_d = crc_cnt_q + 4'd1;
            end
          end
        end
        ST_END: begin
          if (sample_en_i) begin
            if (dat_in_i != END_PATTERN) begin
              crc_err_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      nib_cnt_q   <= '0;
      crc_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      hi_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      hi_q        <= hi_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      crc_err_q   <= crc_err_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign crc_err_o   = crc_err_q;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Self-checking bench for sd_dat_block_rx with a 4-byte block and an
// 8-tick start-bit timeout. Payload bytes are checked through a scoreboard
// queue; block-level results come from a small vector table plus
// hand-written sequences for overrun, timeout and abort.
module tb_sd_dat_block_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sampleEn = 1'b0;
  logic [3:0] datIn = 4'hF;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady = 1'b1;
  logic       done;
  logic       crcErr;
  logic       timeoutFlag;
  logic       overrun;

  int testsRun = 0;
  int testsFailed = 0;
  int doneCount = 0;
  logic [7:0] expQ [$];
  logic [7:0] expByte;

  typedef struct {
    string      name;
    logic [31:0] payload;
    int         flipLine;
    int         flipBit;
    logic [3:0] endPat;
    logic       expCrcErr;
  } vec_t;

  vec_t vectors [3];

  sd_dat_block_rx #(.BLOCK_BYTES(4), .TIMEOUT_TICKS(8)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .sample_en_i (sampleEn),
    .dat_in_i    (datIn),
    .start_i     (start),
    .abort_i     (abort),
    .busy_o      (busy),
    .out_data_o  (outData),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .done_o      (done),
    .crc_err_o   (crcErr),
    .timeout_o   (timeoutFlag),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Drives one clock of inputs and returns 1ns after the edge that used them.
  task automatic applyStimulus(input logic [3:0] d, input logic se, input logic st, input logic ab);
    @(posedge clk); #1;
    datIn = d; sampleEn = se; start = st; abort = ab;
    @(posedge clk); #1;
    sampleEn = 1'b0; start = 1'b0; abort = 1'b0; datIn = 4'hF;
  endtask

  function automatic logic [15:0] crcLine(input logic [31:0] payload, input int line);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      b = payload[31 - 8*j -: 8];
      for (int h = 1; h >= 0; h--) begin
        fb = b[line + 4*h] ^ c[15];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic sendHeader(input string name);
    applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);
    checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sendByte(input string name, input logic [7:0] b, input bit push, input bit checkValid);
    applyStimulus(b[7:4], 1'b1, 1'b0, 1'b0);
    if (push) expQ.push_back(b);
    applyStimulus(b[3:0], 1'b1, 1'b0, 1'b0);
    if (checkValid) begin
      checkOutput({name, " valid after low nibble"}, 32'(outValid), 32'd1);
      checkOutput({name, " data after low nibble"}, 32'(outData), 32'(b));
    end
  endtask

  task automatic sendTrailer(input logic [31:0] payload, input int flipLine, input int flipBit, input logic [3:0] endPat);
    logic [15:0] crcs [4];
    logic [3:0]  nib;
    for (int l = 0; l < 4; l++) crcs[l] = crcLine(payload, l);
    if (flipLine >= 0) crcs[flipLine][flipBit] = ~crcs[flipLine][flipBit];
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) nib[l] = crcs[l][15 - k];
      applyStimulus(nib, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(endPat, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic runBlock(input vec_t v, input logic expOverrun);
    int doneBefore;
    doneBefore = doneCount;
    sendHeader(v.name);
    for (int j = 0; j < 4; j++) sendByte(v.name, v.payload[31 - 8*j -: 8], 1'b1, 1'b1);
    sendTrailer(v.payload, v.flipLine, v.flipBit, v.endPat);
    checkOutput({v.name, " done"}, 32'(done), 32'd1);
    checkOutput({v.name, " busy with done"}, 32'(busy), 32'd0);
    checkOutput({v.name, " crc_err"}, 32'(crcErr), 32'(v.expCrcErr));
    checkOutput({v.name, " overrun"}, 32'(overrun), 32'(expOverrun));
    @(posedge clk); #1;
    checkOutput({v.name, " done single pulse"}, 32'(done), 32'd0);
    checkOutput({v.name, " done count"}, 32'(doneCount - doneBefore), 32'd1);
    checkOutput({v.name, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && outValid && outReady) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected byte: got %02h, required none", outData);
      end else begin
        expByte = expQ.pop_front();
        checkOutput("scoreboard byte", 32'(outData), 32'(expByte));
      end
    end
    if (!reset && done) doneCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    vectors[0] = '{"good block", 32'hA53CFF00, -1, 0, 4'b1111, 1'b0};
    vectors[1] = '{"dat2 crc bit7 flipped", 32'hA53CFF00, 2, 7, 4'b1111, 1'b1};
    vectors[2] = '{"bad end pattern", 32'hA53CFF00, -1, 0, 4'b1011, 1'b1};

    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset crc_err", 32'(crcErr), 32'd0);
    checkOutput("reset timeout", 32'(timeoutFlag), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle out_valid", 32'(outValid), 32'd0);
    checkOutput("idle done", 32'(done), 32'd0);

    // Table-driven complete blocks.
    for (int v = 0; v < 3; v++) runBlock(vectors[v], 1'b0);

    // Missing start bit: timeout on the 8th sample point.
    doneBefore = doneCount;
    applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
      if (t == 7) begin
        checkOutput("timeout before limit", 32'(timeoutFlag), 32'd0);
        checkOutput("busy before limit", 32'(busy), 32'd1);
      end
    end
    checkOutput("timeout at limit", 32'(timeoutFlag), 32'd1);
    checkOutput("busy at timeout", 32'(busy), 32'd0);
    checkOutput("out_valid at timeout", 32'(outValid), 32'd0);
    checkOutput("no done on timeout", 32'(doneCount - doneBefore), 32'd0);

    // Overrun: consumer stalled across two bytes; second byte is dropped.
    outReady = 1'b0;
    sendHeader("overrun");
    checkOutput("timeout cleared by start", 32'(timeoutFlag), 32'd0);
    sendByte("overrun A5", 8'hA5, 1'b1, 1'b1);
    sendByte("overrun 3C", 8'h3C, 1'b0, 1'b0);
    checkOutput("overrun flag", 32'(overrun), 32'd1);
    checkOutput("overrun held data", 32'(outData), 32'hA5);
    checkOutput("overrun held valid", 32'(outValid), 32'd1);
    outReady = 1'b1;
    sendByte("overrun FF", 8'hFF, 1'b1, 1'b1);
    sendByte("overrun 00", 8'h00, 1'b1, 1'b1);
    sendTrailer(32'hA53CFF00, -1, 0, 4'b1111);
    checkOutput("overrun done", 32'(done), 32'd1);
    checkOutput("overrun crc_err", 32'(crcErr), 32'd0);
    checkOutput("overrun sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    checkOutput("overrun scoreboard drained", 32'(expQ.size()), 32'd0);

    // Abort on DATA nibble 3, together with its sample point.
    doneBefore = doneCount;
    outReady = 1'b0;
    sendHeader("abort");
    sendByte("abort A5", 8'hA5, 1'b0, 1'b1);
    applyStimulus(4'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'hC, 1'b1, 1'b0, 1'b1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort out_valid", 32'(outValid), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort no done pulse", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("abort stays idle", 32'(busy), 32'd0);
    runBlock(vectors[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
